adpll_lock_monitor: RTL and testbench
=====================================

// Module: adpll_lock_monitor
// PURPOSE
//  Consumes one ADPLL tile's divided output (gen_div8) and the reference that tile tracks.
//  Counts rising edges of each over a fixed gate window of fpga_clk_i cycles.
//  Reports both counts and their signed difference, and runs a lock-qualification FSM.
//  Instantiated once per tile in the ring-network top; feeds LEDs and the 7-seg display path.
// PARAMETERS
//  GATE_CYCLES     4096  gate window length in fpga_clk_i cycles (>=16)
//  CNT_WIDTH       12    width of each edge counter; counters saturate at 2**CNT_WIDTH-1
//  TOL             2     max |fb_count - ref_count| for a window to be "good"
//  LOCK_WINDOWS    4     consecutive good windows needed to declare lock (>=1)
//  UNLOCK_WINDOWS  2     consecutive bad windows needed to drop lock (>=1)
// PORTS
//  fpga_clk_i    in   1            sampling clock (258 MHz domain)
//  rst_n_i       in   1            reset, asynchronous assert, active-low
//  enable_i      in   1            0: hold block idle and cleared
//  ref_i         in   1            reference clock, asynchronous to fpga_clk_i
//  fb_i          in   1            ADPLL gen_div8 output, asynchronous to fpga_clk_i
//  ref_count_o   out  CNT_WIDTH    ref edges counted in the last completed window
//  fb_count_o    out  CNT_WIDTH    fb edges counted in the last completed window
//  freq_err_o    out  CNT_WIDTH+1  signed fb_count - ref_count, two's complement
//  valid_o       out  1            1-cycle pulse when the outputs above update
//  locked_o      out  1            1 while lock FSM is in LOCKED
//  lock_state_o  out  2            00 UNLOCKED, 01 ACQUIRING, 10 LOCKED
// BEHAVIOUR
//  Reset: all outputs 0; synchronisers, counters and FSM cleared; lock state UNLOCKED.
//  Input capture:
//   - ref_i and fb_i each pass through a 2-flop synchroniser, then a rising-edge detect.
//   - An input rise is counted 3 fpga_clk_i cycles later.
//   - At most one edge per input per cycle.
//  Gate window:
//   - win_cnt runs 0..GATE_CYCLES-1 while enable_i=1, then wraps to 0.
//   - Edges detected on the terminal cycle (win_cnt=GATE_CYCLES-1) belong to the closing window.
//   - Both edge counters restart at 0 on the cycle after the terminal cycle.
//  Result:
//   - On the cycle after the terminal cycle, ref_count_o, fb_count_o and freq_err_o load
//     and valid_o pulses for 1 cycle.
//   - Outputs hold until the next window closes.
//  Arithmetic:
//   - freq_err = zero-extended fb minus zero-extended ref, computed at CNT_WIDTH+1 bits.
//   - A window is good iff neither counter saturated and |freq_err| <= TOL.
//   - A saturated counter forces the window bad.
//  Lock FSM (evaluated once per window close, same cycle as valid_o):
//   - UNLOCKED:  good -> ACQUIRING with good_cnt=1; if LOCK_WINDOWS=1 -> LOCKED directly.
//   - ACQUIRING: good -> good_cnt++, -> LOCKED when good_cnt reaches LOCK_WINDOWS.
//     bad -> UNLOCKED, good_cnt=0.
//   - LOCKED:    bad -> bad_cnt++, -> UNLOCKED when bad_cnt reaches UNLOCK_WINDOWS.
//     good -> bad_cnt=0.
//   - locked_o and lock_state_o are registered and change on the valid_o cycle.
//  enable_i=0, takes effect next cycle:
//   - win_cnt, edge counters, good_cnt and bad_cnt cleared; FSM forced UNLOCKED.
//   - locked_o=0; valid_o held 0; count and err outputs keep their last values.
//   - The synchronisers keep running.
//  enable_i 0->1: a fresh window starts at win_cnt=0. No partial window is ever reported.
//  Async reset mid-window: everything clears immediately; nothing is reported for that window.
// TESTING (GATE_CYCLES=64, CNT_WIDTH=8, TOL=1, LOCK_WINDOWS=4, UNLOCK_WINDOWS=2)
//  1. ref and fb both period 8 clk, in phase
//     -> every valid_o: counts 8/8, err 0.
//     -> lock_state 01 on windows 1-3; locked_o=1 at window 4 close.
//  2. After lock, fb period 4, ref period 8
//     -> err +8; one bad window: still LOCKED.
//     -> second consecutive bad window: UNLOCKED, locked_o=0.
//  3. fb period 16, ref period 8 -> err = -4 (0x1FC in 9 bits); never leaves UNLOCKED.
//  4. Good, good, bad, then good windows
//     -> ACQUIRING resets to UNLOCKED on the bad window.
//     -> locked_o asserts only after 4 further consecutive good windows.
//  5. fb held at 1 (fast toggle forbidden), then fb period 2 with CNT_WIDTH=4
//     -> counter saturates at 15, window bad even if ref also reads 15.
//  6. Drop enable_i mid-window 30 cycles in
//     -> no valid_o, locked_o=0 next cycle.
//     -> re-enable: first valid_o exactly 65 cycles later.
//     -> assert rst_n_i=0 mid-window: all outputs 0 immediately.

Source files
------------

// File: rtl/adpll_lock_monitor.sv
// Per-tile ADPLL lock monitor: counts synchronised ref/fb rising edges over a fixed
// gate window, reports both counts and their signed difference, and qualifies lock.
module adpll_lock_monitor #(
  parameter int GATE_CYCLES    = 4096,
  parameter int CNT_WIDTH      = 12,
  parameter int TOL            = 2,
  parameter int LOCK_WINDOWS   = 4,
  parameter int UNLOCK_WINDOWS = 2
) (
  input  logic                 fpga_clk_i,
  input  logic                 rst_n_i,
  input  logic                 enable_i,
  input  logic                 ref_i,
  input  logic                 fb_i,
  output logic [CNT_WIDTH-1:0] ref_count_o,
  output logic [CNT_WIDTH-1:0] fb_count_o,
  output logic [CNT_WIDTH:0]   freq_err_o,
  output logic                 valid_o,
  output logic                 locked_o,
  output logic [1:0]           lock_state_o
);

  localparam int WIN_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int GC_W  = $clog2(LOCK_WINDOWS + 1);
  localparam int BC_W  = $clog2(UNLOCK_WINDOWS + 1);
  localparam logic [WIN_W-1:0]     WIN_LAST = WIN_W'(GATE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH:0]   TOL_W    = (CNT_WIDTH + 1)'(TOL);
  localparam logic [GC_W-1:0]      LOCK_N   = GC_W'(LOCK_WINDOWS);
  localparam logic [BC_W-1:0]      UNLOCK_N = BC_W'(UNLOCK_WINDOWS);

  typedef enum logic [1:0] {
    UNLOCKED  = 2'b00,
    ACQUIRING = 2'b01,
    LOCKED    = 2'b10
  } lock_state_t;

  logic [1:0]           ref_sync, fb_sync;
  logic                 ref_d, fb_d, ref_edge, fb_edge;
  logic                 en_q, active, terminal;
  logic [WIN_W-1:0]     win_cnt;
  logic [CNT_WIDTH-1:0] ref_cnt, fb_cnt, ref_next, fb_next;
  logic [CNT_WIDTH:0]   err_w, abs_err;
  logic                 sat, good;
  lock_state_t          state_q, state_d;
  logic [GC_W-1:0]      good_cnt_q, good_cnt_d, good_inc;
  logic [BC_W-1:0]      bad_cnt_q, bad_cnt_d, bad_inc;

  // Synchronisers and edge detectors run regardless of enable_i; an edge pulse
  // reaches the counters three cycles after the input rises.
  always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ref_sync <= '0;
      fb_sync  <= '0;
      ref_d    <= 1'b0;
      fb_d     <= 1'b0;
      ref_edge <= 1'b0;
      fb_edge  <= 1'b0;
    end else begin
      ref_sync <= {ref_sync[0], ref_i};
      fb_sync  <= {fb_sync[0], fb_i};
      ref_d    <= ref_sync[1];
      fb_d     <= fb_sync[1];
      ref_edge <= ref_sync[1] & ~ref_d;
      fb_edge  <= fb_sync[1] & ~fb_d;
    end
  end

  // The first enabled cycle only arms the window, so a restart never reports a partial one.
  assign active   = enable_i & en_q;
  assign terminal = active && (win_cnt == WIN_LAST);
  assign ref_next = (ref_edge && (ref_cnt != CNT_MAX)) ? ref_cnt + 1'b1 : ref_cnt;
  assign fb_next  = (fb_edge && (fb_cnt != CNT_MAX)) ? fb_cnt + 1'b1 : fb_cnt;

  assign err_w   = {1'b0, fb_next} - {1'b0, ref_next};
  assign abs_err = err_w[CNT_WIDTH] ? -err_w : err_w;
  assign sat     = (ref_next == CNT_MAX) || (fb_next == CNT_MAX);
  assign good    = !sat && (abs_err <= TOL_W);

  always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      en_q    <= 1'b0;
      win_cnt <= '0;
      ref_cnt <= '0;
      fb_cnt  <= '0;
    end else begin
      en_q <= enable_i;
      if (!enable_i || terminal) begin
        win_cnt <= '0;
        ref_cnt <= '0;
        fb_cnt  <= '0;
      end else if (active) begin
        win_cnt <= win_cnt + 1'b1;
        ref_cnt <= ref_next;
        fb_cnt  <= fb_next;
      end
    end
  end

  always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ref_count_o <= '0;
      fb_count_o  <= '0;
      freq_err_o  <= '0;
      valid_o     <= 1'b0;
    end else begin
      valid_o <= terminal;
      if (terminal) begin
        ref_count_o <= ref_next;
        fb_count_o  <= fb_next;
        freq_err_o  <= err_w;
      end
    end
  end

  assign good_inc = good_cnt_q + 1'b1;
  assign bad_inc  = bad_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    if (!enable_i) begin
      state_d    = UNLOCKED;
      good_cnt_d = '0;
      bad_cnt_d  = '0;
    end else if (terminal) begin
      case (state_q)
        UNLOCKED: begin
          if (good) begin
            if (LOCK_WINDOWS == 1) begin
              state_d    = LOCKED;
              good_cnt_d = '0;
            end else begin
              state_d    = ACQUIRING;
              good_cnt_d = GC_W'(1);
            end
          end
        end
        ACQUIRING: begin
          if (!good) begin
            state_d    = UNLOCKED;
            good_cnt_d = '0;
          end else if (good_inc >= LOCK_N) begin
            state_d    = LOCKED;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
          end else begin
            good_cnt_d = good_inc;
          end
        end
        LOCKED: begin
          if (good) begin
            bad_cnt_d = '0;
          end else if (bad_inc >= UNLOCK_N) begin
            state_d   = UNLOCKED;
            bad_cnt_d = '0;
          end else begin
            bad_cnt_d = bad_inc;
          end
        end
        default: begin
          state_d    = UNLOCKED;
          good_cnt_d = '0;
          bad_cnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= UNLOCKED;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
    end
  end

  assign lock_state_o = state_q;
  assign locked_o     = (state_q == LOCKED);

endmodule

// File: tb/tb_adpll_lock_monitor.sv
// Directed bench for adpll_lock_monitor: lock acquire/loss, slow fb, reacquire,
// counter saturation (second instance with 4-bit counters), enable drop and async reset.
module tb_adpll_lock_monitor;

  logic       clk, rst_n, enable, ref_in, fb_in;
  logic [7:0] ref_count, fb_count;
  logic [8:0] freq_err;
  logic       valid, locked;
  logic [1:0] lock_state;
  logic [3:0] ref_count4, fb_count4;
  logic [4:0] freq_err4;
  logic       valid4, locked4;
  logic [1:0] lock_state4;

  int tests = 0;
  int fails = 0;
  int unsigned ref_per = 8;
  int unsigned fb_per  = 8;
  logic        fb_hold = 1'b0;
  int unsigned t = 0;

  adpll_lock_monitor #(.GATE_CYCLES(64), .CNT_WIDTH(8), .TOL(1),
                       .LOCK_WINDOWS(4), .UNLOCK_WINDOWS(2)) u_dut (
    .fpga_clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .ref_i(ref_in), .fb_i(fb_in),
    .ref_count_o(ref_count), .fb_count_o(fb_count), .freq_err_o(freq_err),
    .valid_o(valid), .locked_o(locked), .lock_state_o(lock_state)
  );

  adpll_lock_monitor #(.GATE_CYCLES(64), .CNT_WIDTH(4), .TOL(1),
                       .LOCK_WINDOWS(4), .UNLOCK_WINDOWS(2)) u_dut4 (
    .fpga_clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .ref_i(ref_in), .fb_i(fb_in),
    .ref_count_o(ref_count4), .fb_count_o(fb_count4), .freq_err_o(freq_err4),
    .valid_o(valid4), .locked_o(locked4), .lock_state_o(lock_state4)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ref/fb pattern generator; period 0 means hold (ref low, fb at fb_hold)
  initial begin
    ref_in = 1'b0;
    fb_in  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      t++;
      ref_in = (ref_per == 0) ? 1'b0 : ((t % ref_per) < (ref_per / 2));
      fb_in  = (fb_per == 0) ? fb_hold : ((t % fb_per) < (fb_per / 2));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL wait_valid: no valid_o within 200 cycles (t=%0t)", $time);
    end
  endtask

  task automatic restart(input int unsigned rp, input int unsigned fp, input logic fh);
    enable = 1'b0;
    step();
    ref_per = rp;
    fb_per  = fp;
    fb_hold = fh;
    repeat (8) step();
    enable = 1'b1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (4) step();
    tests++; if ({ref_count, fb_count, freq_err, valid, locked, lock_state} !== '0) begin
      fails++; $display("FAIL reset_outputs: got %h required 0",
                        {ref_count, fb_count, freq_err, valid, locked, lock_state}); end
    tests++; if ({ref_count4, fb_count4, freq_err4, valid4, locked4, lock_state4} !== '0) begin
      fails++; $display("FAIL reset_outputs4: got %h required 0",
                        {ref_count4, fb_count4, freq_err4, valid4, locked4, lock_state4}); end
    rst_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_lock_acquire();
    bit ok;
    restart(8, 8, 1'b0);
    for (int w = 1; w <= 5; w++) begin
      wait_valid(ok);
      tests++; if (ref_count !== 8'd8 || fb_count !== 8'd8 || freq_err !== 9'd0) begin
        fails++; $display("FAIL acq_counts w%0d: got ref=%0d fb=%0d err=%h required 8/8/000",
                          w, ref_count, fb_count, freq_err); end
      tests++; if (lock_state !== ((w < 4) ? 2'b01 : 2'b10) || locked !== (w >= 4)) begin
        fails++; $display("FAIL acq_state w%0d: got state=%b locked=%b required %b/%b",
                          w, lock_state, locked, (w < 4) ? 2'b01 : 2'b10, w >= 4); end
      if (w == 1) begin
        step();
        tests++; if (valid !== 1'b0) begin
          fails++; $display("FAIL valid_pulse_width: got %b required 0", valid); end
      end
    end
  endtask

  task automatic test_unlock();
    bit ok;
    fb_per = 4;
    wait_valid(ok);
    tests++; if (lock_state !== 2'b10 || locked !== 1'b1) begin
      fails++; $display("FAIL unlock_first_bad: got state=%b locked=%b required 10/1",
                        lock_state, locked); end
    wait_valid(ok);
    tests++; if (ref_count !== 8'd8 || fb_count !== 8'd16 || freq_err !== 9'd8) begin
      fails++; $display("FAIL unlock_counts: got ref=%0d fb=%0d err=%h required 8/16/008",
                        ref_count, fb_count, freq_err); end
    tests++; if (lock_state !== 2'b00 || locked !== 1'b0) begin
      fails++; $display("FAIL unlock_second_bad: got state=%b locked=%b required 00/0",
                        lock_state, locked); end
  endtask

  task automatic test_slow_fb();
    bit ok;
    restart(8, 16, 1'b0);
    for (int w = 1; w <= 3; w++) begin
      wait_valid(ok);
      tests++; if (ref_count !== 8'd8 || fb_count !== 8'd4 || freq_err !== 9'h1FC) begin
        fails++; $display("FAIL slow_counts w%0d: got ref=%0d fb=%0d err=%h required 8/4/1fc",
                          w, ref_count, fb_count, freq_err); end
      tests++; if (lock_state !== 2'b00 || locked !== 1'b0) begin
        fails++; $display("FAIL slow_state w%0d: got state=%b locked=%b required 00/0",
                          w, lock_state, locked); end
    end
  endtask

  task automatic test_reacquire();
    bit ok;
    logic [1:0] exp_state [1:7] = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10};
    restart(8, 8, 1'b0);
    for (int w = 1; w <= 7; w++) begin
      wait_valid(ok);
      tests++; if (lock_state !== exp_state[w] || locked !== (w == 7)) begin
        fails++; $display("FAIL reacq_state w%0d: got state=%b locked=%b required %b/%b",
                          w, lock_state, locked, exp_state[w], w == 7); end
      if (w == 2) fb_per = 16;
      if (w == 3) fb_per = 8;
    end
  endtask

  task automatic test_saturation();
    bit ok;
    restart(8, 0, 1'b1);
    wait_valid(ok);
    tests++; if (ref_count !== 8'd8 || fb_count !== 8'd0 || freq_err !== 9'h1F8) begin
      fails++; $display("FAIL hold_counts: got ref=%0d fb=%0d err=%h required 8/0/1f8",
                        ref_count, fb_count, freq_err); end
    tests++; if (ref_count4 !== 4'd8 || fb_count4 !== 4'd0 || freq_err4 !== 5'h18 ||
                 lock_state4 !== 2'b00) begin
      fails++; $display("FAIL hold_counts4: got ref=%0d fb=%0d err=%h st=%b required 8/0/18/00",
                        ref_count4, fb_count4, freq_err4, lock_state4); end
    restart(4, 2, 1'b0);
    for (int w = 1; w <= 2; w++) begin
      wait_valid(ok);
      tests++; if (ref_count !== 8'd16 || fb_count !== 8'd32 || freq_err !== 9'd16) begin
        fails++; $display("FAIL fast_counts w%0d: got ref=%0d fb=%0d err=%h required 16/32/010",
                          w, ref_count, fb_count, freq_err); end
      tests++; if (ref_count4 !== 4'd15 || fb_count4 !== 4'd15 || freq_err4 !== 5'd0) begin
        fails++; $display("FAIL sat_counts w%0d: got ref=%0d fb=%0d err=%h required 15/15/00",
                          w, ref_count4, fb_count4, freq_err4); end
      tests++; if (lock_state4 !== 2'b00 || locked4 !== 1'b0) begin
        fails++; $display("FAIL sat_state w%0d: got state=%b locked=%b required 00/0",
                          w, lock_state4, locked4); end
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    bit seen;
    int n;
    restart(8, 8, 1'b0);
    for (int w = 1; w <= 4; w++) wait_valid(ok);
    tests++; if (locked !== 1'b1) begin
      fails++; $display("FAIL drop_prelock: got locked=%b required 1", locked); end
    repeat (30) step();
    enable = 1'b0;
    step();
    tests++; if (locked !== 1'b0 || lock_state !== 2'b00) begin
      fails++; $display("FAIL drop_unlock: got locked=%b state=%b required 0/00",
                        locked, lock_state); end
    tests++; if (ref_count !== 8'd8 || fb_count !== 8'd8 || freq_err !== 9'd0) begin
      fails++; $display("FAIL drop_hold: got ref=%0d fb=%0d err=%h required 8/8/000",
                        ref_count, fb_count, freq_err); end
    seen = 1'b0;
    for (int i = 0; i < 150; i++) begin
      step();
      if (valid !== 1'b0) seen = 1'b1;
    end
    tests++; if (seen) begin
      fails++; $display("FAIL drop_no_valid: got valid=1 while disabled required 0"); end
    enable = 1'b1;
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (valid === 1'b1) begin
        n = i;
        break;
      end
    end
    tests++; if (n != 65) begin
      fails++; $display("FAIL reenable_latency: got %0d cycles required 65", n); end
    tests++; if (ref_count !== 8'd8 || fb_count !== 8'd8 || lock_state !== 2'b01) begin
      fails++; $display("FAIL reenable_first: got ref=%0d fb=%0d state=%b required 8/8/01",
                        ref_count, fb_count, lock_state); end
    repeat (30) step();
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if ({ref_count, fb_count, freq_err, valid, locked, lock_state} !== '0) begin
      fails++; $display("FAIL async_reset: got %h required 0",
                        {ref_count, fb_count, freq_err, valid, locked, lock_state}); end
    #2;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    test_reset();
    test_lock_acquire();
    test_unlock();
    test_slow_fb();
    test_reacquire();
    test_saturation();
    test_enable_drop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
